// File: rtl/mul_sequencer.sv
// Multi-cycle multiply controller: one 16x16 unsigned multiplier stepped over four
// partial-product cycles to produce MUL/MLA/UMULL/UMLAL/SMULL/SMLAL results.
module mul_sequencer #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [2:0]   op,
  input  logic [N-1:0] rm,
  input  logic [N-1:0] rs,
  input  logic [N-1:0] acc_lo,
  input  logic [N-1:0] acc_hi,
  input  logic         flush,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result_lo,
  output logic [N-1:0] result_hi,
  output logic [1:0]   nz
);

  // state | meaning
  // IDLE  | waiting for start; operands captured on accept
  // PP0   | add m.lo*s.lo << 0
  // PP1   | add m.lo*s.hi << 16
  // PP2   | add m.hi*s.lo << 16
  // PP3   | add m.hi*s.hi << 32
  // FIN   | apply sign, add accumulator, register results and flags
  typedef enum logic [2:0] {IDLE, PP0, PP1, PP2, PP3, FIN} state_t;

  state_t      state;
  logic [31:0] m, s;
  logic        neg, is_long, is_acc;
  logic [63:0] addend, acc;
  logic [15:0] mul_a, mul_b;
  logic [31:0] pp;
  logic [63:0] pp_sh, prod, sum;
  logic        signed_op;
  logic [31:0] rm_mag, rs_mag;

  assign signed_op = (op[2:1] == 2'b11);
  assign rm_mag    = (signed_op && rm[31]) ? (~rm + 32'd1) : rm;
  assign rs_mag    = (signed_op && rs[31]) ? (~rs + 32'd1) : rs;

  always_comb begin
    mul_a = m[15:0];
    mul_b = s[15:0];
    unique case (state)
      PP1:     mul_b = s[31:16];
      PP2:     mul_a = m[31:16];
      PP3: begin
        mul_a = m[31:16];
        mul_b = s[31:16];
      end
      default: ;
    endcase
  end

  assign pp = 32'(mul_a) * 32'(mul_b);

  always_comb begin
    pp_sh = '0;
    unique case (state)
      PP0:      pp_sh = {32'd0, pp};
      PP1, PP2: pp_sh = {16'd0, pp, 16'd0};
      PP3:      pp_sh = {pp, 32'd0};
      default:  ;
    endcase
  end

  // Magnitude product is negated here so the accumulate addend stays a plain sum.
  assign prod = neg ? (~acc + 64'd1) : acc;
  assign sum  = prod + addend;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      result_lo <= '0;
      result_hi <= '0;
      nz        <= 2'b00;
      m         <= '0;
      s         <= '0;
      neg       <= 1'b0;
      is_long   <= 1'b0;
      is_acc    <= 1'b0;
      addend    <= '0;
      acc       <= '0;
    end else begin
      done <= 1'b0;
      if (state != IDLE && flush) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start && !flush) begin
              m       <= rm_mag;
              s       <= rs_mag;
              neg     <= signed_op & (rm[31] ^ rs[31]);
              is_long <= op[2];
              is_acc  <= (op == 3'b001) | (op[2] & op[0]);
              if (op == 3'b001)
                addend <= {32'd0, acc_lo};
              else if (op[2] & op[0])
                addend <= {acc_hi, acc_lo};
              else
                addend <= '0;
              acc   <= '0;
              busy  <= 1'b1;
              state <= PP0;
            end
          end
          PP0: begin
            acc   <= acc + pp_sh;
            state <= PP1;
          end
          PP1: begin
            acc   <= acc + pp_sh;
            state <= PP2;
          end
          PP2: begin
            acc   <= acc + pp_sh;
            state <= PP3;
          end
          PP3: begin
            acc   <= acc + pp_sh;
            state <= FIN;
          end
          FIN: begin
            result_lo <= sum[31:0];
            if (is_long) begin
              result_hi <= sum[63:32];
              nz        <= {sum[63], (sum == 64'd0)};
            end else begin
              result_hi <= '0;
              nz        <= {sum[31], (sum[31:0] == 32'd0)};
            end
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
          default: begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mul_sequencer.sv
// Scoreboard bench for mul_sequencer: expected results queued at issue, popped on done.
module tb_mul_sequencer;

  logic        clk = 1'b0;
  logic        rst_n, start, flush;
  logic [2:0]  op;
  logic [31:0] rm, rs, acc_lo, acc_hi;
  logic        busy, done;
  logic [31:0] result_lo, result_hi;
  logic [1:0]  nz;

  always #5 clk = ~clk;

  mul_sequencer #(.N(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .rm(rm), .rs(rs),
    .acc_lo(acc_lo), .acc_hi(acc_hi), .flush(flush), .busy(busy), .done(done),
    .result_lo(result_lo), .result_hi(result_hi), .nz(nz)
  );

  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
    logic [1:0]  nz;
  } exp_t;

  exp_t sb[$];
  exp_t last;
  int   tests = 0;
  int   fails = 0;

  function automatic exp_t model(input logic [2:0] o, input logic [31:0] a, b, al, ah);
    exp_t        e;
    logic [63:0] p, sm;
    bit          lng, ac;
    if (o == 3'b110 || o == 3'b111)
      p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    else
      p = {32'd0, a} * {32'd0, b};
    lng = (o == 3'b100 || o == 3'b101 || o == 3'b110 || o == 3'b111);
    ac  = (o == 3'b001 || o == 3'b101 || o == 3'b111);
    sm  = p;
    if (ac) sm = p + (lng ? {ah, al} : {32'd0, al});
    e.lo = sm[31:0];
    if (lng) begin
      e.hi = sm[63:32];
      e.nz = {sm[63], (sm == 64'd0)};
    end else begin
      e.hi = 32'd0;
      e.nz = {sm[31], (sm[31:0] == 32'd0)};
    end
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input logic [2:0] o, input logic [31:0] a, b, al, ah, input string nm);
    exp_t e;
    int   cyc, bc;
    sb.push_back(model(o, a, b, al, ah));
    op = o; rm = a; rs = b; acc_lo = al; acc_hi = ah; start = 1'b1;
    step();
    start = 1'b0;
    rm = $urandom; rs = $urandom; acc_lo = $urandom; acc_hi = $urandom; op = 3'($urandom);
    cyc = 1; bc = 0;
    while (!done && cyc < 20) begin
      if (busy) bc++;
      step();
      cyc++;
    end
    tests++;
    if (cyc !== 6) begin
      fails++;
      $display("FAIL %s latency: done after %0d cycles, want 6", nm, cyc);
    end
    tests++;
    if (bc !== 5) begin
      fails++;
      $display("FAIL %s busy_len: busy %0d cycles, want 5", nm, bc);
    end
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL %s busy_at_done: got %b want 0", nm, busy);
    end
    e = sb.pop_front();
    tests++;
    if (result_hi !== e.hi || result_lo !== e.lo || nz !== e.nz) begin
      fails++;
      $display("FAIL %s result: got hi=%h lo=%h nz=%b want hi=%h lo=%h nz=%b",
               nm, result_hi, result_lo, nz, e.hi, e.lo, e.nz);
    end
    last = e;
    step();
    tests++;
    if (done !== 1'b0 || result_lo !== e.lo || result_hi !== e.hi || nz !== e.nz) begin
      fails++;
      $display("FAIL %s hold: done=%b hi=%h lo=%h nz=%b want done=0 hi=%h lo=%h nz=%b",
               nm, done, result_hi, result_lo, nz, e.hi, e.lo, e.nz);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = '0;
    rm = '0; rs = '0; acc_lo = '0; acc_hi = '0;
    step(); step();
    tests++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL reset_ctl: busy=%b done=%b want 0 0", busy, done);
    end
    tests++;
    if (result_lo !== 32'd0 || result_hi !== 32'd0 || nz !== 2'b00) begin
      fails++;
      $display("FAIL reset_out: hi=%h lo=%h nz=%b want 0 0 00", result_hi, result_lo, nz);
    end
    rst_n = 1'b1;
    last = '{lo: 32'd0, hi: 32'd0, nz: 2'b00};
    step();
  endtask

  task automatic test_basic();
    do_op(3'b000, 32'd7, 32'd6, 32'd0, 32'd0, "mul_7x6");
    do_op(3'b001, 32'hFFFF_FFFF, 32'd2, 32'd5, 32'd0, "mla");
    do_op(3'b100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, "umull_max");
    do_op(3'b110, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'd0, "smull_neg");
    do_op(3'b111, 32'h8000_0000, 32'h8000_0000, 32'd1, 32'd0, "smlal_min");
    do_op(3'b101, 32'd0, 32'd5, 32'd0, 32'd0, "umlal_zero");
  endtask

  task automatic test_random();
    logic [2:0] ops[8] = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111, 3'b010, 3'b011};
    for (int i = 0; i < 8; i++)
      do_op(ops[i], $urandom, $urandom, $urandom, $urandom, $sformatf("rand%0d", i));
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   cyc, nd;
    int   t0, t1;
    sb.push_back(model(3'b000, 32'd100, 32'd200, 32'd0, 32'd0));
    sb.push_back(model(3'b000, 32'd12345, 32'd678, 32'd0, 32'd0));
    op = 3'b000; rm = 32'd100; rs = 32'd200; acc_lo = '0; acc_hi = '0; start = 1'b1;
    step();
    cyc = 1; nd = 0; t0 = 0; t1 = 0;
    while (cyc <= 20) begin
      if (done) begin
        if (nd == 0) t0 = cyc;
        if (nd == 1) t1 = cyc;
        nd++;
        if (sb.size() > 0) begin
          e = sb.pop_front();
          tests++;
          if (result_lo !== e.lo || result_hi !== e.hi || nz !== e.nz) begin
            fails++;
            $display("FAIL b2b_result%0d: got hi=%h lo=%h nz=%b want hi=%h lo=%h nz=%b",
                     nd, result_hi, result_lo, nz, e.hi, e.lo, e.nz);
          end
          last = e;
        end
      end
      if (cyc == 6) begin rm = 32'd12345; rs = 32'd678; end
      if (cyc == 7) start = 1'b0;
      step();
      cyc++;
    end
    tests++;
    if (nd !== 2) begin
      fails++;
      $display("FAIL b2b_count: got %0d dones want 2", nd);
    end
    tests++;
    if (t0 !== 6 || t1 !== 12) begin
      fails++;
      $display("FAIL b2b_timing: got cycles %0d,%0d want 6,12", t0, t1);
    end
    sb.delete();
  endtask

  task automatic test_flush();
    op = 3'b100; rm = 32'h1234_5678; rs = 32'h9ABC_DEF0; start = 1'b1;
    step();
    start = 1'b0;
    step(); step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    tests++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL flush_ctl: busy=%b done=%b want 0 0", busy, done);
    end
    tests++;
    if (result_lo !== last.lo || result_hi !== last.hi || nz !== last.nz) begin
      fails++;
      $display("FAIL flush_hold: got hi=%h lo=%h nz=%b want hi=%h lo=%h nz=%b",
               result_hi, result_lo, nz, last.hi, last.lo, last.nz);
    end
    do_op(3'b000, 32'd9, 32'd9, 32'd0, 32'd0, "after_flush");
    // flush with a coincident start in IDLE must drop the start
    start = 1'b1; flush = 1'b1;
    step();
    start = 1'b0; flush = 1'b0;
    step();
    tests++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL idle_flush_start: busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  task automatic test_reset_midop();
    int nd;
    op = 3'b111; rm = 32'h0000_0003; rs = 32'h0000_0005; acc_lo = 32'd1; acc_hi = 32'd0;
    start = 1'b1;
    step();
    start = 1'b0;
    step(); step(); step();
    rst_n = 1'b0;
    step();
    tests++;
    if (busy !== 1'b0 || done !== 1'b0 || result_lo !== 32'd0 || result_hi !== 32'd0 || nz !== 2'b00) begin
      fails++;
      $display("FAIL midop_reset: busy=%b done=%b hi=%h lo=%h nz=%b want all 0",
               busy, done, result_hi, result_lo, nz);
    end
    rst_n = 1'b1;
    last = '{lo: 32'd0, hi: 32'd0, nz: 2'b00};
    nd = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (done) nd++;
    end
    tests++;
    if (nd !== 0) begin
      fails++;
      $display("FAIL midop_reset_nodone: got %0d dones want 0", nd);
    end
    do_op(3'b110, 32'd3, 32'hFFFF_FFFC, 32'd0, 32'd0, "smull_after_reset");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_random();
    test_back_to_back();
    test_flush();
    test_reset_midop();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mul_sequencer.md
# mul_sequencer

Multi-cycle multiply controller for the execute stage. It sequences a single internal 16x16 unsigned multiplier over four partial-product cycles to produce the results of the ARM multiply family: MUL, MLA, UMULL, UMLAL, SMULL and SMLAL. It holds the pipeline with `busy` while working and returns a registered 64-bit result with N/Z flags. It replaces the single-cycle 32x32 low-product multiplier path and adds long and accumulate support.

## Interface
Parameters:
- `N`, 32, operand width; only 32 is supported.

Ports:
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `start`  in  1  request; sampled only in IDLE.
- `op`  in  3  operation: 000 MUL, 001 MLA, 100 UMULL, 101 UMLAL, 110 SMULL, 111 SMLAL; other codes behave as MUL.
- `rm`  in  32  multiplicand.
- `rs`  in  32  multiplier.
- `acc_lo`  in  32  accumulate low word (Rn for MLA, RdLo for *MLAL).
- `acc_hi`  in  32  accumulate high word (RdHi for *MLAL); ignored otherwise.
- `flush`  in  1  abort the current operation.
- `busy`  out  1  operation in flight; the pipeline stalls on it.
- `done`  out  1  one-cycle pulse; results valid.
- `result_lo`  out  32  product/sum bits 31:0.
- `result_hi`  out  32  bits 63:32 for long ops; 0 for MUL/MLA.
- `nz`  out  2  {N, Z} of the result.

## Operation
- States: IDLE, PP0, PP1, PP2, PP3, FIN.
- IDLE with `start` = 1 captures operands and goes to PP0; the 64-bit accumulator register is cleared.
  - Signed ops (`op[2:1]` = 11): store the magnitudes of `rm`/`rs` and `neg` = `rm[31]` ^ `rs[31]`.
  - Other ops: operands are taken unsigned and `neg` = 0.
  - MUL/MLA are computed unsigned; the low 32 bits are identical to signed.
  - 0x80000000 has magnitude 2^31, which fits unsigned in 32 bits.
- Partial products, each added into the 64-bit accumulator:
  - PP0: `m[15:0]*s[15:0]`, shift 0.
  - PP1: `m[15:0]*s[31:16]`, shift 16.
  - PP2: `m[31:16]*s[15:0]`, shift 16.
  - PP3: `m[31:16]*s[31:16]`, shift 32.
- FIN:
  - Product P = `neg` ? two's-complement negate of the accumulator : accumulator.
  - Accumulate ops add {`acc_hi`, `acc_lo`} for long ops or {0, `acc_lo`} for MLA. Addends are captured at start; the sum is modulo 2^64.
  - Register the results. Short ops take `result_lo` = sum[31:0] and `result_hi` = 0.
  - Go to IDLE.
- Flags:
  - Long ops: N = bit 63, Z = (64-bit result == 0).
  - Short ops: N = bit 31, Z = (`result_lo` == 0).
- `flush` = 1 in any non-IDLE state: next state IDLE, no `done`, and outputs keep their previous values.
- Priority: `rst_n` low > `flush` > `start`.
- `start` while busy is ignored; it is not queued.
- `flush` in IDLE has no effect, and a coincident `start` is dropped.

## Timing
- Reset (`rst_n` = 0 at an edge):
  - State goes to IDLE.
  - `busy` = 0, `done` = 0, `result_lo` = 0, `result_hi` = 0, `nz` = 00.
  - The accumulator and captured operands are cleared.
  - Reset mid-operation aborts it without a `done`.
- Fixed latency for every op. `start` is sampled at edge E0; `busy` = 1 from after E0 through after E4; FIN executes at edge E5.
- `done` = 1 and results are valid in the cycle after E5. `busy` = 0 in that same cycle, so a new `start` may be accepted at E6.
  - Back-to-back throughput is one op per 6 cycles.
- `busy` is registered (state != IDLE); it is never combinational from `start`.
- `result_*`/`nz` hold until the next FIN or reset. `done` deasserts after one cycle.
- Operand inputs may change after E0 without affecting the result.

## Test plan
- MUL `rm`=7, `rs`=6 -> `done` at cycle E0+6, `result_lo`=0x0000002A, `result_hi`=0, `nz`=00. `busy` high for exactly 5 cycles.
- MLA `rm`=0xFFFFFFFF, `rs`=2, `acc_lo`=5 -> `result_lo`=0x00000003, `nz`=00. UMULL 0xFFFFFFFF*0xFFFFFFFF -> hi 0xFFFFFFFE, lo 0x00000001.
- Signed products:
  - SMULL -1 * 2 -> hi 0xFFFFFFFF, lo 0xFFFFFFFE, `nz`=10.
  - SMLAL 0x80000000*0x80000000 with acc {0,1} -> hi 0x40000000, lo 0x00000001.
  - UMLAL 0*5 with acc {0,0} -> 0, `nz`=01.
- Back-to-back: two MULs, the second `start` held high during the first and asserted in the first's `done` cycle -> only the `done`-cycle `start` is accepted. Results arrive 6 cycles apart, with no extra op.
- `flush` asserted in PP2 -> IDLE next cycle, no `done`, prior results unchanged. A new `start` in the following cycle completes normally.
- `rst_n` low during PP3 -> IDLE, all outputs 0, no `done`. After release, SMULL 3 * -4 -> lo 0xFFFFFFF4, hi 0xFFFFFFFF.
